// File: rtl/mulacc_pkg.sv
// mulacc_pkg: shared constants and state encoding for the shift-add multiply-accumulate unit.
package mulacc_pkg;
    localparam int WIDTH = 32;
    localparam int CNT_W = 5;
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
endpackage

// File: rtl/mulacc32_step.sv
// mulacc32_step: one shift-add iteration, kept separate so the adder can later be retimed or unrolled.
module mulacc32_step
    import mulacc_pkg::*;
(
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [2*WIDTH-1:0] mcand_i,
    input  logic               mplier_lsb_i,
    output logic [2*WIDTH-1:0] acc_o
);
    always_comb acc_o = mplier_lsb_i ? acc_i + mcand_i : acc_i;
endmodule

// File: rtl/mulacc32.sv
// mulacc32: sequential x = q*d + r, one multiplier bit per cycle, valid/ready on both sides.
module mulacc32
    import mulacc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     q,
    input  logic [WIDTH-1:0]     d,
    input  logic [WIDTH-1:0]     r,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   x
);
    state_e               state_q;
    logic [2*WIDTH-1:0]   acc_q, mcand_q, x_q, acc_d;
    logic [WIDTH-1:0]     mplier_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 out_valid_q;

    mulacc32_step u_step (
        .acc_i        (acc_q),
        .mcand_i      (mcand_q),
        .mplier_lsb_i (mplier_q[0]),
        .acc_o        (acc_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            x_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (in_valid) begin
                    acc_q    <= {{WIDTH{1'b0}}, r};
                    mcand_q  <= {{WIDTH{1'b0}}, d};
                    mplier_q <= q;
                    cnt_q    <= '0;
                    state_q  <= S_BUSY;
                end
                S_BUSY: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q     <= S_DONE;
                        x_q         <= acc_d;
                        out_valid_q <= 1'b1;
                    end
                end
                S_DONE: if (out_ready) begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign x         = x_q;
endmodule
